regfile_32x32: RTL and testbench



---
 rtl/regfile_32x32.sv | 79 +++++++
 tb/tb_regfile_32x32.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_32x32.sv
// Architectural integer register file: 32 x 32-bit, one synchronous write
// port, two combinational read ports with optional same-cycle write bypass.
// x0 reads as zero and has no storage behind it.
module regfile_32x32 #(
    parameter bit          BYPASS_EN = 1'b1,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_rd_wren,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data
);

    // Only x1..x31 are real flops; x0 is a constant in the read view.
    logic [31:0] regs    [1:31];
    logic [31:0] rd_view [0:31];
    logic [31:0] rs1_mux;
    logic [31:0] rs2_mux;
    logic        wr_en;
    logic        fwd_en;

    // A write to x0 is dropped here so no register ever sees it.
    assign wr_en  = i_rd_wren && (i_rd_addr != 5'd0);
    // Forwarding is suppressed during reset so reads show the reset contents.
    assign fwd_en = BYPASS_EN && i_rst_n && wr_en;

    // Register storage: async reset to RESET_VAL, write on rising edge.
    // NOTE: this array is reset on purpose -- software may read any register
    // before writing it, so every flop must come out of reset defined.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                // NOTE: non-blocking assignment keeps every flop sampling the
                // pre-edge value, independent of statement order.
                if (wr_en && (i_rd_addr == 5'(i))) begin
                    regs[i] <= i_rd_data;
                end
            end
        end
    end

    // Read view feeding both 32:1 muxes: d0 is hardwired zero, d1..d31 are the flops.
    always_comb begin
        // NOTE: every element is assigned on every pass, so no latch is inferred.
        rd_view[0] = 32'h0000_0000;
        for (int i = 1; i < 32; i++) begin
            rd_view[i] = regs[i];
        end
    end

    // One 32:1 mux per read port, selected by the read address.
    always_comb begin
        rs1_mux = rd_view[i_rs1_addr];
        rs2_mux = rd_view[i_rs2_addr];
    end

    // Per-port bypass: a matching same-cycle writeback overrides the mux.
    // x0 never matches because fwd_en already excludes i_rd_addr == 0.
    always_comb begin
        o_rs1_data = rs1_mux;
        o_rs2_data = rs2_mux;
        if (fwd_en && (i_rd_addr == i_rs1_addr)) begin
            o_rs1_data = i_rd_data;
        end
        if (fwd_en && (i_rd_addr == i_rs2_addr)) begin
            o_rs2_data = i_rd_data;
        end
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Self-checking bench for regfile_32x32. Two instances share all inputs:
// dut_a (bypass on, reset value 0) and dut_b (bypass off, non-zero reset value).
// The driver pushes expected read data into a queue; a separate monitor pops
// and compares each entry against both instances.
module tb_regfile_32x32;

    localparam logic [31:0] RST_A = 32'h0000_0000;
    localparam logic [31:0] RST_B = 32'hCAFE_0001;

    typedef struct {
        string       name;
        logic [31:0] rs1_a;
        logic [31:0] rs2_a;
        logic [31:0] rs1_b;
        logic [31:0] rs2_b;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;

    exp_t        exp_q[$];
    event        chk_ev;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] model_a [0:31];
    logic [31:0] model_b [0:31];

    regfile_32x32 #(.BYPASS_EN(1'b1), .RESET_VAL(RST_A)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_wren(rd_wren), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(rs1_a), .o_rs2_data(rs2_a)
    );

    regfile_32x32 #(.BYPASS_EN(1'b0), .RESET_VAL(RST_B)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_wren(rd_wren), .i_rd_addr(rd_addr),
        .i_rd_data(rd_data), .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
        .o_rs1_data(rs1_b), .o_rs2_data(rs2_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value from the reference register contents.
    function automatic logic [31:0] exp_read(input bit byp, input logic [31:0] rst_val,
                                             input logic [31:0] cur, input logic [4:0] a);
        if (a == 5'd0)                                   return 32'h0;
        if (!rst_n)                                      return rst_val;
        if (byp && rd_wren && rd_addr != 5'd0 && rd_addr == a) return rd_data;
        return cur;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            model_a[i] = (i == 0) ? 32'h0 : RST_A;
            model_b[i] = (i == 0) ? 32'h0 : RST_B;
        end
    endtask

    // Queue the expected outputs for the current inputs and hand off to the monitor.
    task automatic check_now(input string name);
        exp_t e;
        e.name  = name;
        e.rs1_a = exp_read(1'b1, RST_A, model_a[rs1_addr], rs1_addr);
        e.rs2_a = exp_read(1'b1, RST_A, model_a[rs2_addr], rs2_addr);
        e.rs1_b = exp_read(1'b0, RST_B, model_b[rs1_addr], rs1_addr);
        e.rs2_b = exp_read(1'b0, RST_B, model_b[rs2_addr], rs2_addr);
        exp_q.push_back(e);
        -> chk_ev;
        #2;
    endtask

    // One clock cycle: drive, check combinational reads, clock, update model.
    task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input string name);
        rd_wren  = we;
        rd_addr  = wa;
        rd_data  = wd;
        rs1_addr = r1;
        rs2_addr = r2;
        check_now(name);
        @(posedge clk);
        if (rst_n && we && wa != 5'd0) begin
            model_a[wa] = wd;
            model_b[wa] = wd;
        end
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop one expectation per handoff and compare all four outputs.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard: check requested with empty queue");
            end else begin
                e = exp_q.pop_front();
                cmp({e.name, " a.rs1"}, rs1_a, e.rs1_a);
                cmp({e.name, " a.rs2"}, rs2_a, e.rs2_a);
                cmp({e.name, " b.rs1"}, rs1_b, e.rs1_b);
                cmp({e.name, " b.rs2"}, rs2_b, e.rs2_b);
            end
        end
    end

    initial begin
        int guard;
        rst_n    = 1'b0;
        rd_wren  = 1'b0;
        rd_addr  = 5'd0;
        rd_data  = 32'h0;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset: sweep reads, and try a write to x5 that must be blocked.
        for (int k = 0; k < 32; k++) begin
            cyc(k == 4 || k == 5, 5'd5, 32'h5555_AAAA, 5'(k), 5'(31 - k), "reset_sweep");
        end
        rst_n = 1'b1;
        cyc(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, "after_reset_x5");

        // Write all registers, then read back through both ports.
        for (int k = 1; k < 32; k++) begin
            cyc(1'b1, 5'(k), 32'hA5A5_0000 | 32'(k), 5'd0, 5'd0, "write_all");
        end
        for (int k = 0; k < 32; k++) begin
            cyc(1'b0, 5'd0, 32'h0, 5'(k), 5'(31 - k), "read_all");
        end

        // x0 protection, same cycle and next cycle.
        cyc(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "x0_write_same");
        cyc(1'b0, 5'd0, 32'h0,         5'd0, 5'd0, "x0_write_next");

        // Bypass on both ports at once (dut_a forwards, dut_b shows old value).
        cyc(1'b1, 5'd7, 32'h1111_1111, 5'd3, 5'd4, "bypass_setup");
        cyc(1'b1, 5'd7, 32'hDEAD_BEEF, 5'd7, 5'd7, "bypass_same");
        cyc(1'b0, 5'd0, 32'h0,         5'd7, 5'd7, "bypass_next");
        // One port matches, the other does not.
        cyc(1'b1, 5'd9, 32'h0BAD_F00D, 5'd9, 5'd7, "bypass_one_port");

        // Async reset between edges.
        cyc(1'b1, 5'd31, 32'h1234_5678, 5'd31, 5'd9, "x31_write");
        rd_wren  = 1'b0;
        rs1_addr = 5'd31;
        rs2_addr = 5'd9;
        check_now("x31_before_reset");
        #1;
        rst_n = 1'b0;
        model_reset();
        check_now("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 5'd31, 32'h7777_0000, 5'd31, 5'd0, "first_write_after_reset");
        cyc(1'b0, 5'd0,  32'h0,         5'd31, 5'd0, "first_write_visible");

        // Random traffic against the reference model.
        for (int n = 0; n < 2000; n++) begin
            cyc(1'($urandom), 5'($urandom), $urandom, 5'($urandom), 5'($urandom), "random");
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            #1;
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
